snake_input_frontend: RTL and testbench
=======================================

SNAKE_INPUT_FRONTEND -- requirements
Module: snake_input_frontend

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, cycles a synchronized button level must stay stable before acceptance.
REQ-003 clk  input  1  system clock; only clock, all flops on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 arriba, abajo, izquierda, derecha, pausa  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 le  input  1  load enable from consumer; low for one cycle = command consumed.
REQ-007 clk_1hz, clk_2hz, clk_1khz  output  1 each  divided square-wave clocks, 50% duty.
REQ-008 boton_pres  output  3  one-cycle press code: 0 none, 1 up, 2 down, 3 left, 4 right, 5 pause; codes 6-7 never driven.
REQ-009 memoria  output  3  latched pending command, same encoding as boton_pres.

Function -- frequency divider
REQ-010 Three independent counters SHALL toggle clk_1khz every CLK_FREQ_HZ/2000 cycles, clk_2hz every CLK_FREQ_HZ/4 cycles, clk_1hz every CLK_FREQ_HZ/2 cycles.
REQ-011 Each counter SHALL count 0..N-1, toggle its output when reaching N-1, and wrap to 0 in the same cycle; no drift.
REQ-012 Counter widths SHALL be derived from CLK_FREQ_HZ (clog2) and never overflow.

Function -- input handling
REQ-013 Each button SHALL pass a 2-flop synchronizer before any other logic.
REQ-014 Each synchronized button SHALL have its own debouncer: debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
REQ-015 A press event SHALL be the 0-to-1 transition of a debounced level; releases produce no event.
REQ-016 On a press event boton_pres SHALL show that button's code for exactly one clk cycle, then return to 0; holding a button SHALL NOT repeat the event.
REQ-017 Simultaneous press events in one cycle SHALL resolve by fixed priority pausa > arriba > abajo > izquierda > derecha; lower-priority events that cycle are discarded.
REQ-018 Latency raw press to boton_pres SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, fixed.

Function -- command memory
REQ-019 When boton_pres != 0, memoria SHALL load boton_pres on the next clock edge, overwriting any pending command (last press wins).
REQ-020 When le is low and boton_pres == 0, memoria SHALL clear to 0 on the next edge; the consumer samples the pre-clear value in the le-low cycle.
REQ-021 When le is low and boton_pres != 0 in the same cycle, the new code SHALL be loaded (new press wins over consume).
REQ-022 Otherwise memoria SHALL hold its value.

Reset
REQ-023 rst low SHALL immediately and asynchronously force clk_1hz=0, clk_2hz=0, clk_1khz=0, boton_pres=0, memoria=0, all counters, synchronizers and debounced levels to 0.
REQ-024 Release of rst SHALL be synchronized internally to clk; divider counting resumes from 0 on the first edge after release.
REQ-025 A button held through reset release SHALL produce one press event after the normal debounce latency.
REQ-026 Reset asserted mid-debounce or mid-period SHALL discard partial counts; no event or toggle is generated by the reset itself.

Verification (CLK_FREQ_HZ=8000, DEBOUNCE_CYCLES=4)
REQ-027 Divider: after reset release, clk_1khz toggles every 4 cycles, clk_2hz every 2000, clk_1hz every 4000; all start low.
REQ-028 Debounce: arriba high 3 cycles then low -> boton_pres stays 0; arriba held 20 cycles -> boton_pres=1 for exactly one cycle, 7 cycles after assertion, memoria=1 next cycle.
REQ-029 Priority: pausa and derecha rise same cycle -> boton_pres=5 once, derecha event lost, memoria=5.
REQ-030 Consume: memoria=3, pulse le low one cycle with no press -> memoria=0 next cycle; repeat with boton_pres=2 in that cycle -> memoria=2.
REQ-031 Overwrite: izquierda press then abajo press, le held high -> memoria 3 then 2.
REQ-032 Async reset: assert rst low between clock edges with memoria=4 and clk_1khz=1 -> both 0 immediately, before the next edge.

Source files
------------

// File: rtl/snake_input_frontend.sv
// rtl/snake_input_frontend.sv - button front end and clock dividers for the snake game
//
// Purpose: divides the system clock into 1 kHz / 2 Hz / 1 Hz square waves and
// turns five raw push-buttons into single-cycle press codes plus a latched
// pending command that the consumer clears by pulsing le low.
//
// Ports:
//   clk                      system clock, all flops on rising edge
//   rst                      asynchronous active-low reset (release synchronized)
//   arriba/abajo/izquierda/
//   derecha/pausa            raw asynchronous buttons, active-high
//   le                       low for one cycle = pending command consumed
//   clk_1hz/clk_2hz/clk_1khz divided 50% duty clocks
//   boton_pres[2:0]          one-cycle press code (0 none,1 up,2 down,3 left,4 right,5 pause)
//   memoria[2:0]             latched pending command, same encoding
module snake_input_frontend #(
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arriba,
  input  logic       abajo,
  input  logic       izquierda,
  input  logic       derecha,
  input  logic       pausa,
  input  logic       le,
  output logic       clk_1hz,
  output logic       clk_2hz,
  output logic       clk_1khz,
  output logic [2:0] boton_pres,
  output logic [2:0] memoria
);

  // Half-period lengths; clamped to 1 so tiny clock frequencies still elaborate.
  localparam int N_1K  = (CLK_FREQ_HZ / 2000 > 1) ? CLK_FREQ_HZ / 2000 : 1;
  localparam int N_2H  = (CLK_FREQ_HZ / 4 > 1)    ? CLK_FREQ_HZ / 4    : 1;
  localparam int N_1H  = (CLK_FREQ_HZ / 2 > 1)    ? CLK_FREQ_HZ / 2    : 1;
  localparam int W_1K  = (N_1K > 1) ? $clog2(N_1K) : 1;
  localparam int W_2H  = (N_2H > 1) ? $clog2(N_2H) : 1;
  localparam int W_1H  = (N_1H > 1) ? $clog2(N_1H) : 1;
  localparam logic [W_1K-1:0] LAST_1K = W_1K'(N_1K - 1);
  localparam logic [W_2H-1:0] LAST_2H = W_2H'(N_2H - 1);
  localparam logic [W_1H-1:0] LAST_1H = W_1H'(N_1H - 1);

  localparam int DEB_N = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
  localparam int DW    = (DEB_N > 1) ? $clog2(DEB_N) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_N - 1);

  // Reset: assertion is immediate, release is aligned to clk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  // Frequency dividers
  logic [W_1K-1:0] cnt_1k_q, cnt_1k_d;
  logic [W_2H-1:0] cnt_2h_q, cnt_2h_d;
  logic [W_1H-1:0] cnt_1h_q, cnt_1h_d;
  logic            clk_1khz_q, clk_1khz_d;
  logic            clk_2hz_q, clk_2hz_d;
  logic            clk_1hz_q, clk_1hz_d;

  always_comb begin
    cnt_1k_d   = cnt_1k_q + W_1K'(1);
    clk_1khz_d = clk_1khz_q;
    if (cnt_1k_q == LAST_1K) begin
      cnt_1k_d   = '0;
      clk_1khz_d = ~clk_1khz_q;
    end

    cnt_2h_d  = cnt_2h_q + W_2H'(1);
    clk_2hz_d = clk_2hz_q;
    if (cnt_2h_q == LAST_2H) begin
      cnt_2h_d  = '0;
      clk_2hz_d = ~clk_2hz_q;
    end

    cnt_1h_d  = cnt_1h_q + W_1H'(1);
    clk_1hz_d = clk_1hz_q;
    if (cnt_1h_q == LAST_1H) begin
      cnt_1h_d  = '0;
      clk_1hz_d = ~clk_1hz_q;
    end
  end

  // Button path; bit index i carries code i+1 (arriba..derecha), pausa is bit 4.
  logic [4:0]    btn_raw;
  logic [4:0]    sync1_q, sync1_d;
  logic [4:0]    sync2_q, sync2_d;
  logic [4:0]    deb_q, deb_d;
  logic [4:0]    deb_prev_q, deb_prev_d;
  logic [DW-1:0] deb_cnt_q [5];
  logic [DW-1:0] deb_cnt_d [5];
  logic [4:0]    rise;
  logic [2:0]    boton_pres_q, boton_pres_d;
  logic [2:0]    memoria_q, memoria_d;

  assign btn_raw = {pausa, derecha, izquierda, abajo, arriba};

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    for (int i = 0; i < 5; i++) begin
      // Count consecutive disagreeing cycles; any agreement restarts the count.
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
    end

    rise = deb_q & ~deb_prev_q;

    // Fixed priority; losers in the same cycle are dropped.
    boton_pres_d = 3'd0;
    if      (rise[4]) boton_pres_d = 3'd5;
    else if (rise[0]) boton_pres_d = 3'd1;
    else if (rise[1]) boton_pres_d = 3'd2;
    else if (rise[2]) boton_pres_d = 3'd3;
    else if (rise[3]) boton_pres_d = 3'd4;

    // A fresh press beats a consume in the same cycle.
    memoria_d = memoria_q;
    if (boton_pres_q != 3'd0) memoria_d = boton_pres_q;
    else if (!le)             memoria_d = 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cnt_1k_q     <= '0;
      cnt_2h_q     <= '0;
      cnt_1h_q     <= '0;
      clk_1khz_q   <= 1'b0;
      clk_2hz_q    <= 1'b0;
      clk_1hz_q    <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_prev_q   <= '0;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
      boton_pres_q <= 3'd0;
      memoria_q    <= 3'd0;
    end else begin
      cnt_1k_q     <= cnt_1k_d;
      cnt_2h_q     <= cnt_2h_d;
      cnt_1h_q     <= cnt_1h_d;
      clk_1khz_q   <= clk_1khz_d;
      clk_2hz_q    <= clk_2hz_d;
      clk_1hz_q    <= clk_1hz_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_prev_d;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      boton_pres_q <= boton_pres_d;
      memoria_q    <= memoria_d;
    end
  end

  assign clk_1khz   = clk_1khz_q;
  assign clk_2hz    = clk_2hz_q;
  assign clk_1hz    = clk_1hz_q;
  assign boton_pres = boton_pres_q;
  assign memoria    = memoria_q;

endmodule

// File: tb/tb_snake_input_frontend.sv
// tb/tb_snake_input_frontend.sv - self-checking bench for snake_input_frontend
module tb_snake_input_frontend;

  localparam int CLK_HZ = 8000;
  localparam int DEB    = 4;

  localparam logic [4:0] M_UP    = 5'b00001;
  localparam logic [4:0] M_DOWN  = 5'b00010;
  localparam logic [4:0] M_LEFT  = 5'b00100;
  localparam logic [4:0] M_RIGHT = 5'b01000;
  localparam logic [4:0] M_PAUSE = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       le  = 1'b1;
  logic [4:0] btn = 5'b0;
  logic       clk_1hz, clk_2hz, clk_1khz;
  logic [2:0] boton_pres, memoria;

  int         tests = 0;
  int         fails = 0;
  logic [2:0] exp_q [$];

  snake_input_frontend #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arriba    (btn[0]),
    .abajo     (btn[1]),
    .izquierda (btn[2]),
    .derecha   (btn[3]),
    .pausa     (btn[4]),
    .le        (le),
    .clk_1hz   (clk_1hz),
    .clk_2hz   (clk_2hz),
    .clk_1khz  (clk_1khz),
    .boton_pres(boton_pres),
    .memoria   (memoria)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every nonzero press code must match the oldest expected one.
  always @(negedge clk) begin
    logic [2:0] exp_code;
    if (boton_pres !== 3'd0) begin
      exp_code = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
      tests++;
      assert (boton_pres === exp_code) else begin
        fails++;
        $error("FAIL sb_press observed=%0d expected=%0d", boton_pres, exp_code);
      end
    end
  end

  function automatic logic get_clk(input int sel);
    case (sel)
      0:       return clk_1khz;
      1:       return clk_2hz;
      default: return clk_1hz;
    endcase
  endfunction

  // Cycles between two consecutive toggles of the selected divided clock.
  task automatic measure(input int sel, input int limit, output int cycles);
    logic prev;
    int   n;
    @(negedge clk);
    prev = get_clk(sel);
    n = 0;
    while (get_clk(sel) == prev && n < limit) begin
      @(negedge clk);
      n++;
    end
    prev = get_clk(sel);
    n = 0;
    while (get_clk(sel) == prev && n < limit) begin
      @(negedge clk);
      n++;
    end
    cycles = (n >= limit) ? -1 : n;
  endtask

  // Raise buttons, expect one code after 2 + DEB + 1 cycles, hold, release.
  task automatic do_press(input logic [4:0] mask, input logic [2:0] code,
                          input logic le_low, input string tag);
    @(posedge clk); #1;
    btn = btn | mask;
    exp_q.push_back(code);
    repeat (6) @(posedge clk);
    #1 check({tag, "_early"}, 32'(boton_pres), 32'd0);
    @(posedge clk);
    #1 check({tag, "_code"}, 32'(boton_pres), 32'(code));
    if (le_low) le = 1'b0;
    @(posedge clk);
    #1 le = 1'b1;
    check({tag, "_pulse_end"}, 32'(boton_pres), 32'd0);
    check({tag, "_mem"}, 32'(memoria), 32'(code));
    repeat (12) @(posedge clk);
    #1 btn = btn & ~mask;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    int n;
    int guard;

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_1khz", 32'(clk_1khz), 32'd0);
    check("rst_clk_2hz", 32'(clk_2hz), 32'd0);
    check("rst_clk_1hz", 32'(clk_1hz), 32'd0);
    check("rst_boton", 32'(boton_pres), 32'd0);
    check("rst_mem", 32'(memoria), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("start_low", 32'({clk_1hz, clk_2hz, clk_1khz}), 32'd0);

    measure(0, 50, n);
    check("div_1khz_half", 32'(n), 32'd4);
    measure(1, 5000, n);
    check("div_2hz_half", 32'(n), 32'd2000);
    measure(2, 9000, n);
    check("div_1hz_half", 32'(n), 32'd4000);

    // Glitch one cycle shorter than the debounce window.
    @(posedge clk); #1 btn[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 btn[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("glitch_mem", 32'(memoria), 32'd0);

    do_press(M_UP, 3'd1, 1'b0, "up");
    do_press(M_PAUSE | M_RIGHT, 3'd5, 1'b0, "prio");

    // Consume with no press, then consume colliding with a new press.
    do_press(M_LEFT, 3'd3, 1'b0, "left");
    @(posedge clk); #1 le = 1'b0;
    check("consume_pre", 32'(memoria), 32'd3);
    @(posedge clk); #1 le = 1'b1;
    check("consume_clr", 32'(memoria), 32'd0);
    do_press(M_DOWN, 3'd2, 1'b1, "consume_press");

    // Overwrite with le held high.
    do_press(M_LEFT, 3'd3, 1'b0, "ovw_left");
    check("ovw_hold", 32'(memoria), 32'd3);
    do_press(M_DOWN, 3'd2, 1'b0, "ovw_down");

    // Async reset mid-debounce with memoria=4 and clk_1khz high.
    do_press(M_RIGHT, 3'd4, 1'b0, "right");
    @(posedge clk); #1 btn[0] = 1'b1;
    exp_q.push_back(3'd1);
    repeat (3) @(posedge clk);
    guard = 0;
    @(negedge clk);
    while (clk_1khz !== 1'b1 && guard < 3) begin
      @(negedge clk);
      guard++;
    end
    check("pre_rst_1khz", 32'(clk_1khz), 32'd1);
    check("pre_rst_mem", 32'(memoria), 32'd4);
    #2 rst = 1'b0;
    #1;
    check("arst_mem", 32'(memoria), 32'd0);
    check("arst_1khz", 32'(clk_1khz), 32'd0);
    check("arst_boton", 32'(boton_pres), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Button held through release yields exactly one event.
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("held_event_seen", 32'(exp_q.size()), 32'd0);
    check("held_event_mem", 32'(memoria), 32'd1);
    btn[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1 check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
